// File: rtl/alu_driver.sv
// Command-side initiator for the combinational ALU: loads a command,
// iterates acc <= alu(op, acc, b) count times, then returns acc.
module alu_driver #(
  parameter int DATA_WIDTH  = 32,
  parameter int OP_WIDTH    = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OP_WIDTH-1:0]    cmd_op,
  input  logic [DATA_WIDTH-1:0]  cmd_a,
  input  logic [DATA_WIDTH-1:0]  cmd_b,
  input  logic [COUNT_WIDTH-1:0] cmd_count,
  output logic [OP_WIDTH-1:0]    alu_op,
  output logic [DATA_WIDTH-1:0]  alu_i1,
  output logic [DATA_WIDTH-1:0]  alu_i2,
  input  logic [DATA_WIDTH-1:0]  alu_o,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [OP_WIDTH-1:0]    op_q, op_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]  b_q, b_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    b_d     = b_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          acc_d = cmd_a;
          b_d   = cmd_b;
          rem_d = cmd_count;
          if (cmd_count == '0) state_d = RESP;
          else                 state_d = EXEC;
        end
      end
      EXEC: begin
        acc_d = alu_o;
        if (rem_q != '0) rem_d = rem_q - 1'b1;
        // remaining==1 means this edge performs the last pass
        if (rem_q <= COUNT_WIDTH'(1)) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      acc_q       <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = rst_n & (state_q == IDLE);
  assign alu_op    = op_q;
  assign alu_i1    = acc_q;
  assign alu_i2    = b_q;
  assign rsp_data  = acc_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a small behavioural ALU attached.
module tb_alu_driver;

  localparam int DW = 32;
  localparam int OW = 4;
  localparam int CW = 8;

  localparam logic [OW-1:0] OP_ADD = 4'h1;
  localparam logic [OW-1:0] OP_INC = 4'h2;
  localparam logic [OW-1:0] OP_DEC = 4'h3;
  localparam logic [OW-1:0] OP_UNK = 4'hF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [OW-1:0] cmd_op = '0;
  logic [DW-1:0] cmd_a = '0;
  logic [DW-1:0] cmd_b = '0;
  logic [CW-1:0] cmd_count = '0;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_i1;
  logic [DW-1:0] alu_i2;
  logic [DW-1:0] alu_o;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          busy;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_o = alu_i1;
    case (alu_op)
      OP_ADD:  alu_o = alu_i1 + alu_i2;
      OP_INC:  alu_o = alu_i1 + 32'd1;
      OP_DEC:  alu_o = alu_i1 - 32'd1;
      default: alu_o = alu_i1;
    endcase
  end

  alu_driver #(
    .DATA_WIDTH (DW),
    .OP_WIDTH   (OW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .cmd_count(cmd_count),
    .alu_op   (alu_op),
    .alu_i1   (alu_i1),
    .alu_i2   (alu_i2),
    .alu_o    (alu_o),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [OW-1:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [CW-1:0] n);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_count = n;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("drain_valid", 32'(rsp_valid), 32'd0);
    chk("drain_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    #5 rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(cmd_ready), 32'd1);
    chk("idle_valid", 32'(rsp_valid), 32'd0);

    // 1: single ADD
    issue(OP_ADD, 32'd5, 32'd3, 8'd1);
    chk("t1_i1", alu_i1, 32'd5);
    chk("t1_i2", alu_i2, 32'd3);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready", 32'(cmd_ready), 32'd0);
    chk("t1_nvalid", 32'(rsp_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_data", rsp_data, 32'd8);
    chk("t1_busy2", 32'(busy), 32'd1);
    drain();
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: repeated ADD, multiply 7 by 6
    issue(OP_ADD, 32'd0, 32'd7, 8'd6);
    for (int k = 0; k < 6; k++) begin
      chk("t2_i1", alu_i1, 32'(7 * k));
      chk("t2_ready", 32'(cmd_ready), 32'd0);
      chk("t2_nvalid", 32'(rsp_valid), 32'd0);
      tick();
    end
    chk("t2_valid", 32'(rsp_valid), 32'd1);
    chk("t2_data", rsp_data, 32'd42);
    drain();

    // 3: zero iterations, unknown op
    issue(OP_UNK, 32'hDEADBEEF, 32'h1234, 8'd0);
    chk("t3_valid", 32'(rsp_valid), 32'd1);
    chk("t3_data", rsp_data, 32'hDEADBEEF);
    chk("t3_busy", 32'(busy), 32'd1);
    drain();

    // 4: INC wraps through zero
    issue(OP_INC, 32'hFFFFFFFE, 32'd0, 8'd3);
    tick();
    tick();
    chk("t4_nvalid", 32'(rsp_valid), 32'd0);
    chk("t4_mid", alu_i1, 32'd0);
    tick();
    chk("t4_valid", 32'(rsp_valid), 32'd1);
    chk("t4_data", rsp_data, 32'd1);
    drain();

    // DEC below zero
    issue(OP_DEC, 32'd0, 32'd0, 8'd1);
    tick();
    chk("dec_data", rsp_data, 32'hFFFFFFFF);
    drain();

    // 5: backpressure with a second command waiting
    issue(OP_ADD, 32'd1, 32'd2, 8'd2);
    tick();
    tick();
    chk("t5_valid", 32'(rsp_valid), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    cmd_a     = 32'd10;
    cmd_b     = 32'd1;
    cmd_count = 8'd1;
    for (int k = 0; k < 5; k++) begin
      chk("t5_data", rsp_data, 32'd5);
      chk("t5_ready", 32'(cmd_ready), 32'd0);
      chk("t5_hold", 32'(rsp_valid), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t5_hs_valid", 32'(rsp_valid), 32'd0);
    chk("t5_hs_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("t5_acc2", alu_i1, 32'd10);
    chk("t5_busy2", 32'(busy), 32'd1);
    tick();
    chk("t5_data2", rsp_data, 32'd11);
    drain();

    // all-ones count
    issue(OP_ADD, 32'd0, 32'd1, 8'hFF);
    for (int k = 0; k < 254; k++) tick();
    chk("max_nvalid", 32'(rsp_valid), 32'd0);
    tick();
    chk("max_valid", 32'(rsp_valid), 32'd1);
    chk("max_data", rsp_data, 32'd255);
    drain();

    // 6: asynchronous reset in the middle of a long run
    issue(OP_ADD, 32'd0, 32'd1, 8'd200);
    for (int k = 0; k < 50; k++) tick();
    chk("t6_mid", alu_i1, 32'd50);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ready", 32'(cmd_ready), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_valid", 32'(rsp_valid), 32'd0);
    chk("t6_data", rsp_data, 32'd0);
    chk("t6_op", 32'(alu_op), 32'd0);
    chk("t6_i1", alu_i1, 32'd0);
    chk("t6_i2", alu_i2, 32'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("t6_rel_ready", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_norsp", 32'(rsp_valid), 32'd0);
      chk("t6_nobusy", 32'(busy), 32'd0);
    end
    issue(OP_ADD, 32'd3, 32'd4, 8'd2);
    tick();
    tick();
    chk("t6_after_valid", 32'(rsp_valid), 32'd1);
    chk("t6_after_data", rsp_data, 32'd11);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
